// File: rtl/uart_tx_frame_arbiter.sv
// Purpose: round-robin arbiter that frames one requester's byte stream (SYNC, ID, payload, CHECKSUM) onto a UART tx port.
// Latency: tx_en rises the cycle after IDLE sees a request with tx_ready high; every byte is one DRIVE plus one RELEASE handshake.
// Backpressure: req_ready only strobes in FETCH for the grantee; FETCH waits forever, tx handshake phases abort after TIMEOUT cycles.
module uart_tx_frame_arbiter #(
  parameter int         N_REQ     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 64,
  parameter int         TIMEOUT   = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               overrun,
  output logic               timeout_err
);

  localparam int             TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]     LEN_MAX = 8'(MAX_LEN);
  localparam logic [3:0]     N_REQ4  = 4'(N_REQ);
  localparam logic [2:0]     PTR_RST = 3'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, SYNC, ID, FETCH, PAY, CSUM} state_t;

  state_t         state;
  logic           release_ph;   // 0: DRIVE (wait tx_ready low), 1: RELEASE (wait tx_ready high)
  logic [2:0]     ptr;          // most recent grantee, lowest priority next time
  logic [7:0]     csum;
  logic [7:0]     len;
  logic           last_q;
  logic [TW-1:0]  timer;

  // Requester buses padded to 8 lanes so a 3-bit grant index selects them directly
  logic [7:0]  vld8;
  logic [7:0]  last8;
  logic [63:0] data64;
  logic [7:0]  gnt_oh;
  assign vld8   = 8'(req_valid);
  assign last8  = 8'(req_last);
  assign data64 = 64'(req_data);
  assign gnt_oh = 8'b1 << grant_id;

  logic [7:0] fetch_byte;
  logic       fetch_ok;
  logic       ph_done;
  logic       ph_expire;
  assign fetch_byte = data64[{grant_id, 3'b000} +: 8];
  assign fetch_ok   = vld8[grant_id];
  assign ph_done    = release_ph ? tx_ready : !tx_ready;
  assign ph_expire  = (timer == T_LAST);

  assign busy      = (state != IDLE);
  assign req_ready = (state == FETCH) ? (req_valid & gnt_oh[N_REQ-1:0]) : '0;

  logic [2:0] pick;
  logic       pick_ok;
  logic [3:0] cand;

  // Round-robin search: first valid requester starting just after the last grantee
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= N_REQ4) cand = cand - N_REQ4;
      if (!pick_ok && vld8[cand[2:0]]) begin
        pick_ok = 1'b1;
        pick    = cand[2:0];
      end
    end
  end

  // Frame sequencer: grant, per-byte DRIVE/RELEASE handshake, payload fetch, checksum, timeout abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      release_ph  <= 1'b0;
      ptr         <= PTR_RST;
      csum        <= '0;
      len         <= '0;
      last_q      <= 1'b0;
      timer       <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_ok && tx_ready) begin
            grant_id   <= pick;
            ptr        <= pick;
            state      <= SYNC;
            tx_en      <= 1'b1;
            tx_data    <= SYNC_BYTE;
            release_ph <= 1'b0;
            timer      <= '0;
          end
        end
        FETCH: begin
          // No timeout here: a slow requester only stalls the frame
          if (fetch_ok) begin
            tx_data    <= fetch_byte;
            csum       <= csum ^ fetch_byte;
            len        <= len + 8'd1;
            last_q     <= last8[grant_id];
            state      <= PAY;
            tx_en      <= 1'b1;
            release_ph <= 1'b0;
            timer      <= '0;
          end
        end
        default: begin
          if (!ph_done) begin
            if (ph_expire) begin
              // Abandon the frame without a checksum; the pointer stays advanced
              timeout_err <= 1'b1;
              tx_en       <= 1'b0;
              state       <= IDLE;
              len         <= '0;
              csum        <= '0;
              release_ph  <= 1'b0;
              timer       <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end else if (!release_ph) begin
            tx_en      <= 1'b0;
            release_ph <= 1'b1;
            timer      <= '0;
          end else begin
            // Byte complete
            release_ph <= 1'b0;
            timer      <= '0;
            case (state)
              SYNC: begin
                state   <= ID;
                tx_en   <= 1'b1;
                tx_data <= {5'b0, grant_id};
                csum    <= {5'b0, grant_id};
              end
              ID: state <= FETCH;
              PAY: begin
                if (last_q || (len == LEN_MAX)) begin
                  state   <= CSUM;
                  tx_en   <= 1'b1;
                  tx_data <= csum;
                  overrun <= !last_q && (len == LEN_MAX);
                end else begin
                  state <= FETCH;
                end
              end
              default: begin
                state <= IDLE;
                len   <= '0;
                csum  <= '0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Purpose: directed bench for uart_tx_frame_arbiter with requester queues, a tx_ready handshake model and a byte scoreboard.
// Latency: expected tx bytes are queued with the stimulus and popped at each tx_en rise.
// Backpressure: the tx model holds tx_ready low/high for programmable cycle counts, or stays high to force a timeout.
module tb_uart_tx_frame_arbiter;

  localparam int N    = 4;
  localparam int MAXL = 4;
  localparam int TMO  = 256;

  logic         clk;
  logic         reset;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic         tx_en;
  logic [7:0]   tx_data;
  logic         tx_ready;
  logic [2:0]   grant_id;
  logic         busy;
  logic         overrun;
  logic         timeout_err;

  uart_tx_frame_arbiter #(
    .N_REQ(N), .SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_en(tx_en), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [8:0] q0[$], q1[$], q2[$], q3[$];
  int         rdy_cnt[N];
  logic [N-1:0] stall = '0;
  int         dly_low = 3;
  int         dly_high = 10;
  bit         stuck = 1'b0;
  bit         quiet = 1'b0;
  bit         model_busy = 1'b0;
  int         ovr_hi = 0;
  int         to_hi = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [8:0] qfront(input int i);
    case (i)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic qpop(input int i);
    case (i)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      2: void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  task automatic qpush(input int i, input logic [7:0] b, input logic l);
    case (i)
      0: q0.push_back({l, b});
      1: q1.push_back({l, b});
      2: q2.push_back({l, b});
      default: q3.push_back({l, b});
    endcase
  endtask

  // Push n expected tx bytes, most significant byte of v first
  task automatic exp_bytes(input int n, input logic [63:0] v);
    for (int k = 0; k < n; k++) exp_q.push_back(v[8*(n-1-k) +: 8]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(busy === 1'b0 && exp_q.size() == 0 && !model_busy && tx_ready) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check(tag, n < budget, 1);
  endtask

  // Requesters: present queue heads at negedge, retire them when the strobe is seen
  initial begin
    logic [8:0] f;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (qsize(i) > 0 && !stall[i]) begin
          f = qfront(i);
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = f[7:0];
          req_last[i] = f[8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      #1;
      if (req_ready != '0) check("req_ready_grantee_only", req_ready, 4'b0001 << grant_id);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          qpop(i);
          rdy_cnt[i]++;
        end
      end
    end
  end

  // UART transmitter model and byte scoreboard
  initial begin
    logic [7:0] cap;
    int n;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tx_en && tx_ready) begin
        model_busy = 1'b1;
        cap = tx_data;
        check("tx_byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_byte", cap, exp_q.pop_front());
        if (!stuck) begin
          repeat (dly_low) @(posedge clk);
          #1 tx_ready = 1'b0;
          n = 0;
          while (tx_en && n < 50) begin @(posedge clk); #1; n++; end
          check("tx_en_release", tx_en, 0);
          repeat (dly_high) @(posedge clk);
          #1;
          if (!quiet) check("tx_data_hold", tx_data, cap);
          tx_ready = 1'b1;
        end else begin
          n = 0;
          while (tx_en && n < TMO + 50) begin @(posedge clk); #1; n++; end
          check("tx_en_abort", tx_en, 0);
        end
        model_busy = 1'b0;
      end
    end
  end

  // Pulse high-cycle counters
  initial begin
    forever begin
      @(posedge clk); #1;
      if (overrun) ovr_hi++;
      if (timeout_err) to_hi++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, b, bad, o0, t0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout_err", timeout_err, 0);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Round robin from reset pointer, then a second burst after granting 3
    exp_bytes(4, 64'hA5_00_F0_F0);
    exp_bytes(4, 64'hA5_01_F0_F1);
    exp_bytes(4, 64'hA5_03_F0_F3);
    qpush(0, 8'hF0, 1'b1);
    qpush(1, 8'hF0, 1'b1);
    qpush(3, 8'hF0, 1'b1);
    wait_idle("rr_burst1_done", 2000);
    check("rr_last_grant", grant_id, 3);
    exp_bytes(4, 64'hA5_00_F0_F0);
    exp_bytes(4, 64'hA5_01_F0_F1);
    qpush(0, 8'hF0, 1'b1);
    qpush(1, 8'hF0, 1'b1);
    wait_idle("rr_burst2_done", 2000);
    check("rr_ready_cnt0", rdy_cnt[0], 2);
    check("rr_ready_cnt1", rdy_cnt[1], 2);
    check("rr_ready_cnt3", rdy_cnt[3], 1);

    // Single frame with slow handshake and tx_en latency
    dly_low = 20;
    dly_high = 150;
    b = rdy_cnt[0];
    exp_bytes(5, 64'hA5_00_11_22_33);
    @(posedge clk);
    qpush(0, 8'h11, 1'b0);
    qpush(0, 8'h22, 1'b1);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!tx_en && n < 10);
    check("single_tx_en_latency", n, 1);
    wait_idle("single_done", 3000);
    check("single_ready_pulses", rdy_cnt[0] - b, 2);
    check("single_grant", grant_id, 0);
    dly_low = 3;
    dly_high = 10;

    // Overrun at MAX_LEN=4, remainder goes out as a second frame
    o0 = ovr_hi;
    exp_bytes(7, 64'hA5_02_01_02_03_04_06);
    exp_bytes(5, 64'hA5_02_05_06_01);
    for (int k = 1; k <= 6; k++) qpush(2, 8'(k), k == 6);
    wait_idle("overrun_done", 2000);
    check("overrun_pulse_cycles", ovr_hi - o0, 1);
    check("overrun_ready_cnt", rdy_cnt[2], 6);

    // Requester 1 goes quiet for 500 cycles mid-frame
    b = rdy_cnt[1];
    exp_bytes(6, 64'hA5_01_31_32_33_31);
    qpush(1, 8'h31, 1'b0);
    n = 0;
    while (rdy_cnt[1] == b && n < 300) begin @(posedge clk); #2; n++; end
    check("stall_first_accept", rdy_cnt[1] - b, 1);
    repeat (40) @(posedge clk);
    #2;
    check("stall_hold_data", tx_data, 8'h31);
    bad = 0;
    repeat (500) begin
      @(posedge clk); #2;
      if (tx_en || tx_data !== 8'h31 || !busy) bad++;
    end
    check("stall_quiet_cycles", bad, 0);
    qpush(1, 8'h32, 1'b0);
    qpush(1, 8'h33, 1'b1);
    wait_idle("stall_done", 2000);

    // Handshake timeout: tx_ready never drops
    stuck = 1'b1;
    t0 = to_hi;
    b = rdy_cnt[3];
    exp_bytes(1, 64'hA5);
    qpush(3, 8'h77, 1'b1);
    n = 0;
    while (!tx_en && n < 10) begin @(posedge clk); #2; n++; end
    check("timeout_tx_en_seen", tx_en, 1);
    stall[3] = 1'b1;
    q3.delete();
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!timeout_err && n < TMO + 20);
    check("timeout_delay_window", (n >= TMO) && (n <= TMO + 1), 1);
    check("timeout_tx_en_low", tx_en, 0);
    check("timeout_busy_low", busy, 0);
    bad = 0;
    repeat (50) begin
      @(posedge clk); #2;
      if (tx_en || busy) bad++;
    end
    check("timeout_no_csum", bad, 0);
    check("timeout_pulse_cycles", to_hi - t0, 1);
    check("timeout_no_ready", rdy_cnt[3] - b, 0);
    stuck = 1'b0;
    stall[3] = 1'b0;

    // Reset during PAY, then pointer restarts from N-1
    quiet = 1'b1;
    b = rdy_cnt[0];
    exp_bytes(3, 64'hA5_00_41);
    qpush(0, 8'h41, 1'b0);
    qpush(0, 8'h42, 1'b0);
    qpush(0, 8'h43, 1'b1);
    n = 0;
    while (rdy_cnt[0] == b && n < 300) begin @(posedge clk); #2; n++; end
    check("rstpay_accept", rdy_cnt[0] - b, 1);
    check("rstpay_tx_en_before", tx_en, 1);
    #1 reset = 1'b1;
    #1;
    check("rstpay_tx_en", tx_en, 0);
    check("rstpay_tx_data", tx_data, 0);
    check("rstpay_req_ready", req_ready, 0);
    check("rstpay_grant_id", grant_id, 0);
    check("rstpay_busy", busy, 0);
    check("rstpay_overrun", overrun, 0);
    check("rstpay_timeout_err", timeout_err, 0);
    q0.delete();
    check("rstpay_bytes_seen", exp_q.size(), 0);
    repeat (30) @(posedge clk);
    #2 reset = 1'b0;
    quiet = 1'b0;
    @(posedge clk);
    #2;
    exp_bytes(4, 64'hA5_00_55_55);
    exp_bytes(4, 64'hA5_02_66_64);
    qpush(2, 8'h66, 1'b1);
    qpush(0, 8'h55, 1'b1);
    wait_idle("post_reset_done", 2000);
    check("post_reset_grant", grant_id, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_arbiter.md
Name: uart_tx_frame_arbiter

Overview:
- Shares the single UART transmitter byte interface (tx_en / tx_data / tx_ready) among N_REQ byte-stream requesters, e.g. per-channel acoustic sample producers and the status reporter.
- Grants one requester at a time in round-robin order and wraps its stream into a frame: SYNC, ID, payload…, CHECKSUM.
- Sequences every byte through the transmitter's slow level handshake: tx_en is held until tx_ready drops, then the block waits for tx_ready to rise again.
- Sits in the 100 MHz domain directly in front of the UART transmitter.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SYNC_BYTE, 8'hA5, first byte of every frame.
- MAX_LEN, 64, maximum payload bytes per frame (1..255).
- TIMEOUT, 4096, clk cycles allowed per tx_ready wait before aborting.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a payload byte available.
- req_data  in  8*N_REQ  payload byte; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  the current byte is the last of requester i's frame.
- req_ready  out  N_REQ  one-cycle accept strobe; byte i is consumed when req_valid[i] & req_ready[i].
- tx_en  out  1  transmit request to the UART transmitter, held high (not pulsed).
- tx_data  out  8  byte to transmit; stable from tx_en rise until tx_ready is seen high again.
- tx_ready  in  1  UART transmitter ready level, already synchronised to clk.
- grant_id  out  3  index of the current or most recent grantee.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  one-cycle pulse when a frame is cut at MAX_LEN.
- timeout_err  out  1  one-cycle pulse on handshake timeout.

Behaviour:
- Reset values (asynchronous): tx_en=0, tx_data=0, req_ready=0, grant_id=0, busy=0, overrun=0, timeout_err=0, state=IDLE, RR pointer=N_REQ-1, checksum=0, length counter=0, timer=0.
- States: IDLE, SYNC, ID, FETCH, PAY, CSUM. Each byte state runs two phases:
  - DRIVE: tx_en=1 with tx_data loaded; wait for tx_ready==0.
  - RELEASE: tx_en=0; wait for tx_ready==1.
- A byte completes when RELEASE sees tx_ready==1.
- IDLE → SYNC:
  - Condition: any req_valid is high and tx_ready==1.
  - Grant the first valid index searching from pointer+1 with wrap-around; register grant_id and update the pointer.
  - tx_en=1 with tx_data=SYNC_BYTE on the next cycle (1-cycle latency).
  - If tx_ready==0 in IDLE, stay in IDLE.
- SYNC complete → ID: tx_data={5'b0, grant_id}; checksum is initialised to that ID byte.
- ID or PAY complete → FETCH.
- FETCH:
  - Wait, without limit, for req_valid[g].
  - On the accepting cycle: req_ready[g]=1 for exactly that cycle, capture the byte, checksum^=byte, len+=1, store last=req_last[g].
  - Next cycle: enter PAY with tx_en=1.
- PAY complete:
  - If last==1 or len==MAX_LEN → CSUM.
  - Otherwise → FETCH.
  - If the frame ends because len==MAX_LEN while last==0, pulse overrun. The requester's remaining bytes go out as a new frame at its next grant.
- CSUM: tx_data=checksum (XOR of ID and all payload bytes). On completion, clear len and checksum and return to IDLE.
- Timeout:
  - The timer restarts on entry to each DRIVE or RELEASE phase.
  - If a phase has not completed when the timer reaches TIMEOUT: pulse timeout_err, drop tx_en, abandon the frame, go to IDLE.
  - An abandoned frame has no checksum byte. The RR pointer stays advanced. No req_ready is issued for the aborted frame from that point on.
- Fairness: req_valid from another requester never interrupts the current frame. Bytes of different frames never interleave.
- Simultaneous requests in IDLE: round-robin order decides the grant. After granting g, g has the lowest priority at the next arbitration.
- req_ready is only ever asserted in FETCH and only for grant_id.
- req_valid falling in FETCH causes a stall only. No timeout applies in FETCH.
- reset asserted mid-frame: all outputs return to reset values immediately and the partial frame is dropped.

Test Plan:
- Single frame: req 0 sends 8'h11, 8'h22 (last) with a tx_ready model (low 20 cycles after tx_en, high 150 cycles later) → tx bytes A5, 00, 11, 22, 33. req_ready[0] pulses twice. tx_en rises 1 cycle after req_valid.
- Round robin: reqs 0, 1 and 3 valid together, each with a 1-byte frame (8'hF0) → frames sent in order ID 00, 01, 03. Checksums F0, F1, F3. A second burst after granting 3 starts at ID 00.
- Overrun: MAX_LEN=4, req 2 streams 6 bytes 01..06 (last on 06):
  - Frame 1: A5, 02, 01, 02, 03, 04, checksum 06, with an overrun pulse.
  - Frame 2: A5, 02, 05, 06, checksum 01.
- Timeout: tx_ready held high after tx_en rises → after TIMEOUT cycles, timeout_err pulses once, tx_en=0, busy=0, no checksum byte is sent.
- Stall and hold: req 1 drops req_valid for 500 cycles mid-frame → no tx_en activity, tx_data unchanged, frame resumes correctly. tx_data stays constant across every DRIVE/RELEASE pair.
- Reset mid-PAY → all outputs are 0 within the reset assertion. After release, the first frame starts from IDLE with the RR pointer reset.
